// File: rtl/muldiv_hilo_seq.sv
// ---------------------------------------------------------------------------
// muldiv_hilo_seq
//   Sequencer and HI/LO register file for an external iterative shift-add
//   multiplier. A MULT request latches the operands, pulses the multiplier's
//   reset/load line for one cycle, waits out MUL_CYCLES iteration clocks,
//   then captures the 64-bit product into {HI,LO}. MFHI/MFLO requests
//   return HI or LO on dataOut with one cycle of latency.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      request strobe, sampled with Signal/dataA/dataB
//   Signal     operation code (SIG_MULT / SIG_MFHI / SIG_MFLO, others ignored)
//   dataA      multiplicand (unsigned)
//   dataB      multiplier (unsigned)
//   prod_in    product returned by the multiplier
//   mul_reset  multiplier reset/load pulse (also high while reset is high)
//   mul_dataA  {32'b0, latched dataA}
//   mul_dataB  latched dataB
//   busy       high in LOAD, RUN and CAPTURE
//   done       one-cycle pulse: HI/LO just updated
//   dataOut    registered MFHI/MFLO result
// ---------------------------------------------------------------------------
module muldiv_hilo_seq #(
    parameter int         MUL_CYCLES = 32,
    parameter logic [5:0] SIG_MULT   = 6'd25,
    parameter logic [5:0] SIG_MFHI   = 6'd16,
    parameter logic [5:0] SIG_MFLO   = 6'd18
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  Signal,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic [63:0] prod_in,
    output logic        mul_reset,
    output logic [63:0] mul_dataA,
    output logic [31:0] mul_dataB,
    output logic        busy,
    output logic        done,
    output logic [31:0] dataOut
);

    localparam int CNT_W = $clog2(MUL_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RUN     = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic [31:0]      hi;
    logic [31:0]      lo;
    // Registered copy of (state == LOAD); keeps mul_reset free of decode glitches.
    logic             load_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
            op_a    <= '0;
            op_b    <= '0;
            hi      <= '0;
            lo      <= '0;
            load_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dataOut <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // Requests are only honoured here; anything arriving while
                    // busy is dropped without side effects.
                    if (start) begin
                        if (Signal == SIG_MULT) begin
                            op_a   <= dataA;
                            op_b   <= dataB;
                            load_q <= 1'b1;
                            busy   <= 1'b1;
                            state  <= LOAD;
                        end else if (Signal == SIG_MFHI) begin
                            dataOut <= hi;
                        end else if (Signal == SIG_MFLO) begin
                            dataOut <= lo;
                        end
                    end
                end
                LOAD: begin
                    load_q  <= 1'b0;
                    counter <= '0;
                    state   <= RUN;
                end
                RUN: begin
                    // Cleared on entry, so it tops out at MUL_CYCLES and never wraps.
                    counter <= counter + 1'b1;
                    if (counter == CNT_LAST)
                        state <= CAPTURE;
                end
                CAPTURE: begin
                    hi    <= prod_in[63:32];
                    lo    <= prod_in[31:0];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    load_q <= 1'b0;
                end
            endcase
        end
    end

    assign mul_reset = reset | load_q;
    assign mul_dataA = {32'b0, op_a};
    assign mul_dataB = op_b;

endmodule

// File: tb/tb_muldiv_hilo_seq.sv
module tb_muldiv_hilo_seq;

    localparam logic [5:0] SIG_MULT = 6'd25;
    localparam logic [5:0] SIG_MFHI = 6'd16;
    localparam logic [5:0] SIG_MFLO = 6'd18;

    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  Signal;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [63:0] prod_in;
    logic        mul_reset;
    logic [63:0] mul_dataA;
    logic [31:0] mul_dataB;
    logic        busy;
    logic        done;
    logic [31:0] dataOut;

    int checks = 0;
    int fails  = 0;

    muldiv_hilo_seq dut (
        .clk(clk), .reset(reset), .start(start), .Signal(Signal),
        .dataA(dataA), .dataB(dataB), .prod_in(prod_in),
        .mul_reset(mul_reset), .mul_dataA(mul_dataA), .mul_dataB(mul_dataB),
        .busy(busy), .done(done), .dataOut(dataOut)
    );

    // Behavioural stand-in for the multiplier: product of the held operands.
    assign prod_in = mul_dataA * {32'b0, mul_dataB};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_reg(input logic [5:0] sig);
        start = 1'b1; Signal = sig;
        step();
        start = 1'b0; Signal = 6'd0;
    endtask

    // Issues one MULT and waits (bounded) for done. done_edge counts edges after
    // the sampling edge (-1 on timeout); busy/mul_reset high cycles are tallied.
    task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                           output int done_edge, output int busy_cnt, output int mrst_cnt);
        start = 1'b1; Signal = SIG_MULT; dataA = a; dataB = b;
        step();
        start = 1'b0; Signal = 6'd0; dataA = '0; dataB = '0;
        done_edge = -1;
        busy_cnt  = int'(busy);
        mrst_cnt  = int'(mul_reset);
        for (int n = 1; n <= 100; n++) begin
            step();
            if (done) begin
                done_edge = n;
                break;
            end
            busy_cnt += int'(busy);
            mrst_cnt += int'(mul_reset);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; Signal = '0; dataA = '0; dataB = '0;
        #1 reset = 1'b1;
        #2;
        checks++; if (mul_reset !== 1'b1) begin fails++; $display("FAIL reset_mul_reset got=%b exp=1", mul_reset); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
        checks++; if (dataOut !== 32'h0) begin fails++; $display("FAIL reset_dataOut got=%h exp=0", dataOut); end
        checks++; if (mul_dataA !== 64'h0 || mul_dataB !== 32'h0) begin fails++; $display("FAIL reset_operands got=%h/%h exp=0/0", mul_dataA, mul_dataB); end
        step(); step();
        reset = 1'b0;
        step();
        checks++; if (mul_reset !== 1'b0) begin fails++; $display("FAIL idle_mul_reset got=%b exp=0", mul_reset); end
    endtask

    task automatic test_basic();
        int de, bc, mc;
        do_mult(32'd7, 32'd6, de, bc, mc);
        checks++; if (de !== 34) begin fails++; $display("FAIL basic_done_edge got=%0d exp=34", de); end
        checks++; if (bc !== 34) begin fails++; $display("FAIL basic_busy_cycles got=%0d exp=34", bc); end
        checks++; if (mc !== 1) begin fails++; $display("FAIL basic_mul_reset_cycles got=%0d exp=1", mc); end
        // MFLO issued in the done cycle must see the new LO.
        read_reg(SIG_MFLO);
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL basic_done_width got=%b exp=0", done); end
        checks++; if (dataOut !== 32'd42) begin fails++; $display("FAIL basic_mflo got=%h exp=%h", dataOut, 32'd42); end
        read_reg(SIG_MFHI);
        checks++; if (dataOut !== 32'd0) begin fails++; $display("FAIL basic_mfhi got=%h exp=0", dataOut); end
    endtask

    task automatic test_max();
        int de, bc, mc;
        do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, de, bc, mc);
        checks++; if (de !== 34) begin fails++; $display("FAIL max_done_edge got=%0d exp=34", de); end
        step();
        read_reg(SIG_MFHI);
        checks++; if (dataOut !== 32'hFFFF_FFFE) begin fails++; $display("FAIL max_mfhi got=%h exp=fffffffe", dataOut); end
        read_reg(SIG_MFLO);
        checks++; if (dataOut !== 32'h0000_0001) begin fails++; $display("FAIL max_mflo got=%h exp=00000001", dataOut); end
    endtask

    task automatic test_zero();
        int de, bc, mc;
        do_mult(32'h1234_5678, 32'h0, de, bc, mc);
        checks++; if (mc !== 1) begin fails++; $display("FAIL zero_mul_reset_cycles got=%0d exp=1", mc); end
        checks++; if (mul_dataA !== 64'h0000_0000_1234_5678) begin fails++; $display("FAIL zero_mul_dataA got=%h exp=0000000012345678", mul_dataA); end
        checks++; if (mul_dataB !== 32'h0) begin fails++; $display("FAIL zero_mul_dataB got=%h exp=0", mul_dataB); end
        read_reg(SIG_MFLO);
        checks++; if (dataOut !== 32'h0) begin fails++; $display("FAIL zero_mflo got=%h exp=0", dataOut); end
        read_reg(SIG_MFHI);
        checks++; if (dataOut !== 32'h0) begin fails++; $display("FAIL zero_mfhi got=%h exp=0", dataOut); end
    endtask

    task automatic test_busy_ignore();
        int de, bc, mc;
        do_mult(32'd9, 32'd9, de, bc, mc);
        read_reg(SIG_MFLO);
        checks++; if (dataOut !== 32'd81) begin fails++; $display("FAIL bi_pre_mflo got=%h exp=%h", dataOut, 32'd81); end
        // 0x10000 * 0x30000 = 0x3_0000_0000
        start = 1'b1; Signal = SIG_MULT; dataA = 32'h0001_0000; dataB = 32'h0003_0000;
        step();
        start = 1'b0; Signal = 6'd0;
        de = -1;
        for (int n = 1; n <= 100; n++) begin
            if (n == 5) begin
                start = 1'b1; Signal = SIG_MULT; dataA = 32'd3; dataB = 32'd3;
            end else if (n == 6) begin
                start = 1'b1; Signal = SIG_MFHI; dataA = '0; dataB = '0;
            end else begin
                start = 1'b0; Signal = 6'd0;
            end
            step();
            if (done) begin de = n; break; end
        end
        start = 1'b0; Signal = 6'd0;
        checks++; if (de !== 34) begin fails++; $display("FAIL bi_done_edge got=%0d exp=34", de); end
        checks++; if (mul_dataA !== 64'h0000_0000_0001_0000 || mul_dataB !== 32'h0003_0000) begin fails++; $display("FAIL bi_operands got=%h/%h exp=0000000000010000/00030000", mul_dataA, mul_dataB); end
        checks++; if (dataOut !== 32'd81) begin fails++; $display("FAIL bi_dataOut_held got=%h exp=%h", dataOut, 32'd81); end
        read_reg(SIG_MFLO);
        checks++; if (dataOut !== 32'h0) begin fails++; $display("FAIL bi_mflo got=%h exp=0", dataOut); end
        read_reg(SIG_MFHI);
        checks++; if (dataOut !== 32'h3) begin fails++; $display("FAIL bi_mfhi got=%h exp=3", dataOut); end
    endtask

    task automatic test_reset_mid();
        int de, bc, mc;
        int seen_done;
        start = 1'b1; Signal = SIG_MULT; dataA = 32'h0000_ABCD; dataB = 32'h0000_1234;
        step();
        start = 1'b0; Signal = 6'd0;
        // One edge into RUN (counter 0), ten more reach counter 10.
        for (int n = 0; n < 11; n++) step();
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL rm_busy_before got=%b exp=1", busy); end
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL rm_async_busy_done got=%b%b exp=00", busy, done); end
        checks++; if (dataOut !== 32'h0 || mul_reset !== 1'b1) begin fails++; $display("FAIL rm_async_dataOut_mrst got=%h/%b exp=0/1", dataOut, mul_reset); end
        step();
        reset = 1'b0;
        seen_done = 0;
        for (int n = 0; n < 40; n++) begin
            step();
            seen_done += int'(done) + int'(busy);
        end
        checks++; if (seen_done !== 0) begin fails++; $display("FAIL rm_no_done got=%0d exp=0", seen_done); end
        read_reg(SIG_MFHI);
        checks++; if (dataOut !== 32'h0) begin fails++; $display("FAIL rm_hi_cleared got=%h exp=0", dataOut); end
        do_mult(32'd5, 32'd5, de, bc, mc);
        checks++; if (de !== 34) begin fails++; $display("FAIL rm_after_done_edge got=%0d exp=34", de); end
        read_reg(SIG_MFLO);
        checks++; if (dataOut !== 32'd25) begin fails++; $display("FAIL rm_after_mflo got=%h exp=%h", dataOut, 32'd25); end
    endtask

    task automatic test_back_to_back();
        int de, bc, mc;
        start = 1'b1; Signal = 6'd20; dataA = 32'd11; dataB = 32'd11;
        step();
        start = 1'b0; Signal = 6'd0;
        checks++; if (busy !== 1'b0 || mul_reset !== 1'b0) begin fails++; $display("FAIL unk_busy_mrst got=%b%b exp=00", busy, mul_reset); end
        checks++; if (dataOut !== 32'd25 || mul_dataA !== 64'd5) begin fails++; $display("FAIL unk_outputs got=%h/%h exp=19/5", dataOut, mul_dataA); end
        do_mult(32'd2, 32'd3, de, bc, mc);
        checks++; if (de !== 34) begin fails++; $display("FAIL b2b_first_done got=%0d exp=34", de); end
        // New MULT presented in the done cycle.
        start = 1'b1; Signal = SIG_MULT; dataA = 32'd4; dataB = 32'd5;
        step();
        start = 1'b0; Signal = 6'd0;
        checks++; if (busy !== 1'b1 || mul_reset !== 1'b1 || mul_dataA !== 64'd4) begin fails++; $display("FAIL b2b_accept got=%b%b/%h exp=11/4", busy, mul_reset, mul_dataA); end
        de = -1;
        for (int n = 1; n <= 100; n++) begin
            step();
            if (done) begin de = n; break; end
        end
        checks++; if (de !== 34) begin fails++; $display("FAIL b2b_second_done got=%0d exp=34", de); end
        read_reg(SIG_MFLO);
        checks++; if (dataOut !== 32'd20) begin fails++; $display("FAIL b2b_mflo got=%h exp=%h", dataOut, 32'd20); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
